// File: rtl/fetch_queue.sv
// fetch_queue: one-outstanding fetcher with prefetch FIFO; FETCH_BYPASS_EN adds an empty-queue ack bypass
module fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_main,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        ins_valid,
  output logic [15:0] ins,
  output logic [15:0] ins_pc,
  input  logic        ins_take
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t        r_state;
  logic [15:0]   r_fetch_pc, r_addr;
  logic [15:0]   r_word [DEPTH];
  logic [15:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          w_enq, w_pop, w_room, w_head;
  assign mem_req  = r_state != IDLE;
  assign mem_addr = r_addr;
  assign w_head   = r_count != '0;
  assign w_pop    = ins_take && w_head && !redirect;
`ifdef FETCH_BYPASS_EN
  logic w_byp;
  assign w_byp     = !w_head && r_state == REQ && mem_ack && !redirect;
  assign w_enq     = r_state == REQ && mem_ack && !redirect && !(w_byp && ins_take);
  assign ins_valid = w_head || w_byp;
  assign ins       = w_head ? r_word[r_rd] : w_byp ? mem_rdata : '0;
  assign ins_pc    = w_head ? r_pc[r_rd]   : w_byp ? r_addr    : '0;
`else
  assign w_enq     = r_state == REQ && mem_ack && !redirect;
  assign ins_valid = w_head;
  assign ins       = w_head ? r_word[r_rd] : '0;
  assign ins_pc    = w_head ? r_pc[r_rd]   : '0;
`endif
  assign w_count_nxt = redirect ? '0 : r_count + (AW+1)'(w_enq) - (AW+1)'(w_pop);
  // room is judged on the post-enqueue/pop count so a request never outruns storage
  assign w_room = w_count_nxt < FULL;
  always_ff @(posedge clk_main) begin
    if (w_enq) begin
      r_word[r_wr] <= mem_rdata;
      r_pc[r_wr]   <= r_addr;
    end
  end
  always_ff @(posedge clk_main) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_rd    <= redirect ? '0 : r_rd + AW'(w_pop);
      r_wr    <= redirect ? '0 : r_wr + AW'(w_enq);
      case (r_state)
        IDLE: begin
          if (redirect) begin
            r_state    <= REQ;
            r_addr     <= redirect_addr;
            r_fetch_pc <= redirect_addr;
          end else if (w_room) begin
            r_state <= REQ;
            r_addr  <= r_fetch_pc;
          end
        end
        REQ: begin
          if (redirect) begin
            r_fetch_pc <= redirect_addr;
            r_state    <= mem_ack ? REQ : DROP;
            r_addr     <= mem_ack ? redirect_addr : r_addr;
          end else if (mem_ack) begin
            r_fetch_pc <= r_addr + 16'd1;
            r_addr     <= r_addr + 16'd1;
            r_state    <= w_room ? REQ : IDLE;
          end
        end
        DROP: begin
          if (redirect) r_fetch_pc <= redirect_addr;
          if (mem_ack) begin
            r_state <= REQ;
            r_addr  <= redirect ? redirect_addr : r_fetch_pc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios against a latency-programmable memory responder
module tb_fetch_queue;
  logic        clk_main = 0, reset = 1;
  logic        mem_req, mem_ack = 0, redirect = 0, ins_valid, ins_take = 0;
  logic [15:0] mem_addr, mem_rdata = 0, redirect_addr = 0, ins, ins_pc;
  int          n_vec = 0, n_err = 0, lat = 1, wait_cnt = 0;

  fetch_queue #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk_main(clk_main), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_addr(redirect_addr), .ins_valid(ins_valid), .ins(ins),
    .ins_pc(ins_pc), .ins_take(ins_take)
  );

  always #5 clk_main = ~clk_main;

  // memory: acks after lat idle cycles of a held request, data = addr ^ A5A5
  always @(negedge clk_main) begin
    mem_ack = 0;
    if (!mem_req || reset) wait_cnt = 0;
    else if (wait_cnt >= lat) begin
      mem_ack   = 1;
      mem_rdata = mem_addr ^ 16'hA5A5;
      wait_cnt  = 0;
    end else wait_cnt++;
  end

  task automatic tick;
    @(posedge clk_main);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; ins_take = 0; redirect = 0; lat = 1;
    tick; tick;
    reset = 0;
  endtask

  task automatic test_reset;
    do_reset;
    tick;
    tick;
    reset = 1;
    tick;
    n_vec++;
    if ({mem_req, mem_addr, ins_valid, ins, ins_pc} !== {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_values: req=%b addr=%h v=%b ins=%h pc=%h, need 0 0000 0 0000 0000", mem_req, mem_addr, ins_valid, ins, ins_pc);
    end
  endtask

  task automatic test_fill_and_pop;
    do_reset;
    tick;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      n_err++; $display("FAIL first_req: req=%b addr=%h, need 1 0000", mem_req, mem_addr);
    end
    tick;
    @(negedge clk_main); #1;
    n_vec++;
    if (ins_valid !== 1'b0) begin
      n_err++; $display("FAIL no_bypass_ack_cycle: valid=%b, need 0", ins_valid);
    end
    @(posedge clk_main); #1;
    n_vec++;
    if ({ins_valid, ins_pc, ins, mem_addr} !== {1'b1, 16'h0000, 16'hA5A5, 16'h0001}) begin
      n_err++; $display("FAIL first_word: v=%b pc=%h ins=%h addr=%h, need 1 0000 a5a5 0001", ins_valid, ins_pc, ins, mem_addr);
    end
    tick; tick;
    n_vec++;
    if ({mem_req, ins_pc, ins} !== {1'b0, 16'h0000, 16'hA5A5}) begin
      n_err++; $display("FAIL full_stall: req=%b pc=%h ins=%h, need 0 0000 a5a5", mem_req, ins_pc, ins);
    end
    tick; tick;
    n_vec++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL full_hold: req=%b, need 0", mem_req);
    end
    ins_take = 1;
    tick;
    ins_take = 0;
    n_vec++;
    if ({mem_req, mem_addr, ins_pc, ins} !== {1'b1, 16'h0002, 16'h0001, 16'hA5A4}) begin
      n_err++; $display("FAIL pop_resume: req=%b addr=%h pc=%h ins=%h, need 1 0002 0001 a5a4", mem_req, mem_addr, ins_pc, ins);
    end
  endtask

  task automatic test_redirect_pending;
    int k;
    do_reset;
    lat = 0; ins_take = 1;
    k = 0;
    while (mem_addr !== 16'h0003 && k < 20) begin tick; k++; end
    n_vec++;
    if (mem_addr !== 16'h0003) begin
      n_err++; $display("FAIL reach_addr3: addr=%h, need 0003", mem_addr);
    end
    lat = 3; ins_take = 0; redirect = 1; redirect_addr = 16'h0040;
    tick;
    redirect = 0;
    n_vec++;
    if ({mem_req, mem_addr, ins_valid} !== {1'b1, 16'h0003, 1'b0}) begin
      n_err++; $display("FAIL drop_hold: req=%b addr=%h v=%b, need 1 0003 0", mem_req, mem_addr, ins_valid);
    end
    tick; tick;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0003}) begin
      n_err++; $display("FAIL drop_wait: req=%b addr=%h, need 1 0003", mem_req, mem_addr);
    end
    tick;
    lat = 0;
    n_vec++;
    if ({mem_req, mem_addr, ins_valid} !== {1'b1, 16'h0040, 1'b0}) begin
      n_err++; $display("FAIL drop_refetch: req=%b addr=%h v=%b, need 1 0040 0", mem_req, mem_addr, ins_valid);
    end
    tick;
    n_vec++;
    if ({ins_valid, ins_pc, ins, mem_addr} !== {1'b1, 16'h0040, 16'hA5E5, 16'h0041}) begin
      n_err++; $display("FAIL redirect_word: v=%b pc=%h ins=%h addr=%h, need 1 0040 a5e5 0041", ins_valid, ins_pc, ins, mem_addr);
    end
  endtask

  task automatic test_redirect_with_ack;
    do_reset;
    tick; tick;
    redirect = 1; redirect_addr = 16'h1234;
    tick;
    redirect = 0;
    n_vec++;
    if ({mem_req, mem_addr, ins_valid} !== {1'b1, 16'h1234, 1'b0}) begin
      n_err++; $display("FAIL ack_redirect: req=%b addr=%h v=%b, need 1 1234 0", mem_req, mem_addr, ins_valid);
    end
    tick;
    n_vec++;
    if (ins_valid !== 1'b0) begin
      n_err++; $display("FAIL ack_discarded: v=%b, need 0", ins_valid);
    end
    tick;
    n_vec++;
    if ({ins_valid, ins_pc, ins} !== {1'b1, 16'h1234, 16'hB791}) begin
      n_err++; $display("FAIL ack_redirect_word: v=%b pc=%h ins=%h, need 1 1234 b791", ins_valid, ins_pc, ins);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    lat = 0; redirect = 1; redirect_addr = 16'hFFFF;
    tick;
    redirect = 0;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 16'hFFFF}) begin
      n_err++; $display("FAIL idle_redirect: req=%b addr=%h, need 1 ffff", mem_req, mem_addr);
    end
    tick;
    n_vec++;
    if ({ins_valid, ins_pc, ins, mem_addr} !== {1'b1, 16'hFFFF, 16'h5A5A, 16'h0000}) begin
      n_err++; $display("FAIL wrap_first: v=%b pc=%h ins=%h addr=%h, need 1 ffff 5a5a 0000", ins_valid, ins_pc, ins, mem_addr);
    end
    ins_take = 1;
    tick;
    ins_take = 0;
    n_vec++;
    if ({ins_valid, ins_pc, ins, mem_addr} !== {1'b1, 16'h0000, 16'hA5A5, 16'h0001}) begin
      n_err++; $display("FAIL wrap_second: v=%b pc=%h ins=%h addr=%h, need 1 0000 a5a5 0001", ins_valid, ins_pc, ins, mem_addr);
    end
  endtask

  task automatic test_bypass;
    do_reset;
    ins_take = 1;
    tick; tick;
    @(negedge clk_main); #1;
    n_vec++;
`ifdef FETCH_BYPASS_EN
    if ({ins_valid, ins, ins_pc} !== {1'b1, 16'hA5A5, 16'h0000}) begin
      n_err++; $display("FAIL bypass_ack_cycle: v=%b ins=%h pc=%h, need 1 a5a5 0000", ins_valid, ins, ins_pc);
    end
`else
    if (ins_valid !== 1'b0) begin
      n_err++; $display("FAIL bypass_ack_cycle: v=%b, need 0", ins_valid);
    end
`endif
    @(posedge clk_main); #1;
    ins_take = 0;
    n_vec++;
`ifdef FETCH_BYPASS_EN
    if (ins_valid !== 1'b0) begin
      n_err++; $display("FAIL bypass_consumed: v=%b, need 0", ins_valid);
    end
`else
    if ({ins_valid, ins, ins_pc} !== {1'b1, 16'hA5A5, 16'h0000}) begin
      n_err++; $display("FAIL bypass_late: v=%b ins=%h pc=%h, need 1 a5a5 0000", ins_valid, ins, ins_pc);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_fill_and_pop;
    test_redirect_pending;
    test_redirect_with_ack;
    test_wrap;
    test_bypass;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage for the 16-bit processor. Runs a one-outstanding req/ack handshake with instruction memory and prefetches sequential words into a small FIFO. Presents the oldest word and its address to the control path, which pops it with its instruction-load strobe. Flushes and refetches from a new address when the control path redirects the PC (branch/jump).

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..8
- RESET_PC, 16'h0000, address of first fetch after reset

Ports:
- clk_main  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- mem_req  output  1  fetch request; held high until mem_ack
- mem_addr  output  16  word address; stable while mem_req high
- mem_ack  input  1  one-cycle pulse; mem_rdata valid in the same cycle
- mem_rdata  input  16  fetched instruction word
- redirect  input  1  one-cycle pulse: flush and refetch from redirect_addr
- redirect_addr  input  16  new fetch address
- ins_valid  output  1  head entry valid
- ins  output  16  head instruction word, to instruction register
- ins_pc  output  16  address of head word
- ins_take  input  1  pop head (IL); ignored when ins_valid=0

## Operation
- Internal state: fetch_pc (16b), FIFO (word+pc per entry), count (0..DEPTH), FSM {IDLE, REQ, DROP}.
- IDLE: mem_req=0. If count<DEPTH, go to REQ next cycle with mem_addr=fetch_pc.
- REQ: mem_req=1. On mem_ack, the word is enqueued with pc=mem_addr, and fetch_pc becomes mem_addr+1 (wraps 16'hFFFF→16'h0000). Stay in REQ presenting the new address next cycle if count after this cycle's enqueue/pop is <DEPTH; otherwise go to IDLE.
- Simultaneous enqueue and pop on a full FIFO is legal; count is unchanged and the request continues.
- The sum of count and outstanding requests never exceeds DEPTH. A request is never issued that cannot be stored.
- redirect (highest priority):
  - FIFO cleared; ins_take in the same cycle is ignored; fetch_pc loads redirect_addr.
  - From IDLE, or REQ with mem_ack that cycle (data discarded): go to REQ at redirect_addr.
  - From REQ without mem_ack: go to DROP.
- DROP: mem_req stays 1 at the old address until mem_ack. That data is discarded, then go to REQ at fetch_pc. A further redirect in DROP only updates fetch_pc.
- ins_valid = (count>0); ins/ins_pc show the head entry, which holds until popped or flushed.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, ins_valid=0, ins=16'h0000, ins_pc=16'h0000, count=0, FSM=IDLE, fetch_pc=RESET_PC.
- First cycle after reset deasserts: mem_req=1, mem_addr=RESET_PC.
- Latency with FETCH_BYPASS_EN undefined: ack in cycle N gives ins_valid=1 in N+1.
- Back-to-back fetch: the next address is presented in cycle N+1 after ack in N. A zero-wait memory yields one word per cycle.
- Redirect in cycle N: ins_valid=0 from N+1. With no request pending, mem_req=1 at redirect_addr in N+1.
- Reset asserted mid-request abandons the transaction. The memory must tolerate a dropped req.

## Configuration
- FETCH_BYPASS_EN:
  - Defined: combinational bypass. When count=0, FSM=REQ, mem_ack=1 and redirect=0, then ins_valid=1, ins=mem_rdata and ins_pc=mem_addr in the ack cycle. If ins_take is also high that cycle, the word is consumed and not enqueued.
  - Undefined: outputs come only from the FIFO, one cycle later, and no combinational path runs from mem_* to ins_*.

## Test plan
- Reset release, memory acks each request the next cycle with data=addr^16'hA5A5 -> addresses 0,1,2… issued; ins_valid in the cycle after the first ack; ins_pc=0, ins=16'hA5A5.
- Consumer holds ins_take=0, DEPTH=2 -> exactly two acks accepted; mem_req=0 with count=2; one pop -> mem_req=1 at addr 2 next cycle.
- Redirect to 16'h0040 while a request to 16'h0003 is pending (ack 3 cycles later) -> mem_addr stays 3 until ack; word discarded; next mem_addr=16'h0040; first ins_pc=16'h0040.
- redirect and mem_ack in the same cycle -> acked word not delivered; mem_req at redirect_addr next cycle; ins_valid=0.
- redirect_addr=16'hFFFF -> fetches 16'hFFFF then 16'h0000; ins_pc sequence FFFF, 0000.
- With FETCH_BYPASS_EN, empty FIFO, ack with ins_take=1 -> ins_valid=1 in the ack cycle; count stays 0; without the macro, ins_valid rises one cycle later.
